time_edit_sequencer: RTL and testbench

// Programming-mode controller for the RTC adjust counters (hours/minutes/seconds, date, timer fields).

---
 rtl/time_edit_sequencer_if.sv | 24 ++
 rtl/time_edit_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_time_edit_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_edit_sequencer_if.sv
// time_edit_sequencer_if: button levels in, field select and step pulses out.
// master = the sequencer, slave = the button/debouncer side.
interface time_edit_sequencer_if;
   logic       prog_mode;
   logic       btn_left;
   logic       btn_right;
   logic       btn_up;
   logic       btn_down;
   logic [3:0] en_count;
   logic       enUP;
   logic       enDOWN;
   logic       editing;
   logic       blink;

   modport master (
      input  prog_mode, btn_left, btn_right, btn_up, btn_down,
      output en_count, enUP, enDOWN, editing, blink
   );

   modport slave (
      output prog_mode, btn_left, btn_right, btn_up, btn_down,
      input  en_count, enUP, enDOWN, editing, blink
   );
endinterface

// File: rtl/time_edit_sequencer.sv
// time_edit_sequencer: programming-mode controller for the RTC field counters.
// Selects a field (en_count), emits single-cycle enUP/enDOWN steps with
// press-and-hold auto-repeat, and drives a blink flag for the display mux.
// Optional feature: define EDIT_TIMEOUT_EN to auto-exit edit mode after
// TIMEOUT_CYC idle cycles in EDIT.
module time_edit_sequencer #(
   parameter logic [3:0]  FIELD_LO    = 4'd1,
   parameter logic [3:0]  FIELD_HI    = 4'd10,
   parameter int unsigned HOLD_CYC    = 50000000,
   parameter int unsigned REPEAT_CYC  = 25000000,
   parameter int unsigned BLINK_CYC   = 25000000,
   parameter int unsigned TIMEOUT_CYC = 1000000000
) (
   input  logic                 clk,
   input  logic                 reset,
   time_edit_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EDIT,
      S_HOLD,
      S_REPEAT
   } state_t;

   localparam logic [31:0] HOLD_LAST   = HOLD_CYC - 32'd1;
   localparam logic [31:0] REPEAT_LAST = REPEAT_CYC - 32'd1;
   localparam logic [31:0] BLINK_LAST  = BLINK_CYC - 32'd1;

   state_t      state_q, state_d;
   logic [3:0]  en_count_q, en_count_d;
   logic        en_up_q, en_up_d;
   logic        en_down_q, en_down_d;
   logic        editing_q, editing_d;
   logic        blink_q, blink_d;
   logic        hold_up_q, hold_up_d;    // 1 = the held step button is btn_up
   logic [31:0] step_cnt_q, step_cnt_d;
   logic [31:0] blink_cnt_q, blink_cnt_d;
   logic        prog_prev_q, left_prev_q, right_prev_q, up_prev_q, down_prev_q;

   logic        rise_prog, rise_left, rise_right, rise_up, rise_down, any_rise;
   logic        both_steps, held_step, exit_edit;
   logic [31:0] step_cnt_inc, blink_cnt_inc;

   assign rise_prog  = bus.prog_mode & ~prog_prev_q;
   assign rise_left  = bus.btn_left  & ~left_prev_q;
   assign rise_right = bus.btn_right & ~right_prev_q;
   assign rise_up    = bus.btn_up    & ~up_prev_q;
   assign rise_down  = bus.btn_down  & ~down_prev_q;
   assign any_rise   = rise_left | rise_right | rise_up | rise_down;
   assign both_steps = bus.btn_up & bus.btn_down;
   assign held_step  = hold_up_q ? bus.btn_up : bus.btn_down;

   // Saturating increments: a counter never wraps back into a trigger value.
   assign step_cnt_inc  = (step_cnt_q  == '1) ? step_cnt_q  : step_cnt_q  + 32'd1;
   assign blink_cnt_inc = (blink_cnt_q == '1) ? blink_cnt_q : blink_cnt_q + 32'd1;

`ifdef EDIT_TIMEOUT_EN
   localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYC - 32'd1;
   logic [31:0] idle_cnt_q, idle_cnt_d;

   assign exit_edit = ((state_q != S_IDLE) && !bus.prog_mode) ||
                      ((state_q == S_EDIT) && !any_rise && (idle_cnt_q >= TIMEOUT_LAST));

   // Inactivity counter: cleared on entry, on any button edge and on any step pulse.
   always_comb begin
      idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 32'd1;
      if (state_q == S_IDLE || state_d == S_IDLE || any_rise || en_up_d || en_down_d) begin
         idle_cnt_d = '0;
      end
   end

   // Inactivity counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) idle_cnt_q <= '0;
      else        idle_cnt_q <= idle_cnt_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
   assign exit_edit      = (state_q != S_IDLE) && !bus.prog_mode;
`endif

   // Next state, field select and step pulse decode
   always_comb begin
      // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latches).
      state_d    = state_q;
      en_count_d = en_count_q;
      en_up_d    = 1'b0;
      en_down_d  = 1'b0;
      hold_up_d  = hold_up_q;
      step_cnt_d = step_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (rise_prog) begin
               state_d    = S_EDIT;
               en_count_d = FIELD_LO;
            end
         end
         S_EDIT: begin
            // A step press wins over navigation; navigation is frozen while any step button is down.
            if (rise_up && !bus.btn_down) begin
               en_up_d    = 1'b1;
               hold_up_d  = 1'b1;
               step_cnt_d = '0;
               state_d    = S_HOLD;
            end else if (rise_down && !bus.btn_up) begin
               en_down_d  = 1'b1;
               hold_up_d  = 1'b0;
               step_cnt_d = '0;
               state_d    = S_HOLD;
            end else if (!bus.btn_up && !bus.btn_down && (rise_left != rise_right)) begin
               if (rise_right) en_count_d = (en_count_q == FIELD_HI) ? FIELD_LO : en_count_q + 4'd1;
               else            en_count_d = (en_count_q == FIELD_LO) ? FIELD_HI : en_count_q - 4'd1;
            end
         end
         S_HOLD, S_REPEAT: begin
            if (both_steps || !held_step) begin
               state_d = S_EDIT;
            end else if (step_cnt_q >= ((state_q == S_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
               en_up_d    = hold_up_q;
               en_down_d  = !hold_up_q;
               step_cnt_d = '0;
               state_d    = S_REPEAT;
            end else begin
               step_cnt_d = step_cnt_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Leaving edit mode outranks everything decoded above.
      if (exit_edit) begin
         state_d    = S_IDLE;
         en_count_d = '0;
         en_up_d    = 1'b0;
         en_down_d  = 1'b0;
      end
      editing_d = (state_d != S_IDLE);
   end

   // Blink generator: restarts low on entry, toggles every BLINK_CYC, low in IDLE
   always_comb begin
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_inc;
      if (state_q == S_IDLE || state_d == S_IDLE) begin
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end else if (blink_cnt_q >= BLINK_LAST) begin
         blink_d     = !blink_q;
         blink_cnt_d = '0;
      end
   end

   // State, output and edge-history registers
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: edge history resets to 0 too; a button held through reset is harmless because IDLE ignores step edges.
      if (!reset) begin
         state_q      <= S_IDLE;
         en_count_q   <= '0;
         en_up_q      <= 1'b0;
         en_down_q    <= 1'b0;
         editing_q    <= 1'b0;
         blink_q      <= 1'b0;
         hold_up_q    <= 1'b0;
         step_cnt_q   <= '0;
         blink_cnt_q  <= '0;
         prog_prev_q  <= 1'b0;
         left_prev_q  <= 1'b0;
         right_prev_q <= 1'b0;
         up_prev_q    <= 1'b0;
         down_prev_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         state_q      <= state_d;
         en_count_q   <= en_count_d;
         en_up_q      <= en_up_d;
         en_down_q    <= en_down_d;
         editing_q    <= editing_d;
         blink_q      <= blink_d;
         hold_up_q    <= hold_up_d;
         step_cnt_q   <= step_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         prog_prev_q  <= bus.prog_mode;
         left_prev_q  <= bus.btn_left;
         right_prev_q <= bus.btn_right;
         up_prev_q    <= bus.btn_up;
         down_prev_q  <= bus.btn_down;
      end
   end

   assign bus.en_count = en_count_q;
   assign bus.enUP     = en_up_q;
   assign bus.enDOWN   = en_down_q;
   assign bus.editing  = editing_q;
   assign bus.blink    = blink_q;

endmodule

// File: tb/tb_time_edit_sequencer.sv
// tb_time_edit_sequencer: table-driven navigation, hand-written hold/repeat,
// exit and reset sequences, and randomized stimulus against a reference model
// built from press ages and modular arithmetic.
module tb_time_edit_sequencer;

   localparam int unsigned HOLD   = 8;
   localparam int unsigned REP    = 4;
   localparam int unsigned BLINK  = 3;
   localparam int unsigned TMO    = 20;
   localparam int          LO     = 1;
   localparam int          HI     = 10;

   logic clk = 1'b0;
   logic reset;

   time_edit_sequencer_if bus();

   time_edit_sequencer #(
      .FIELD_LO   (4'd1),
      .FIELD_HI   (4'd10),
      .HOLD_CYC   (HOLD),
      .REPEAT_CYC (REP),
      .BLINK_CYC  (BLINK),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_edit, m_hold, m_dir_up, m_up, m_dn;
   int m_field, m_hold_age, m_age, m_idle;
   bit pv_p, pv_l, pv_r, pv_u, pv_d;

   task automatic model_reset();
      m_edit = 0; m_hold = 0; m_dir_up = 0; m_up = 0; m_dn = 0;
      m_field = 0; m_hold_age = 0; m_age = 0; m_idle = 0;
      pv_p = 0; pv_l = 0; pv_r = 0; pv_u = 0; pv_d = 0;
   endtask

   task automatic model_step();
      bit p, l, r, u, d, rl, rr, ru, rd, any_rise, hold_at_start;
      p = bus.prog_mode; l = bus.btn_left; r = bus.btn_right; u = bus.btn_up; d = bus.btn_down;
      rl = l && !pv_l; rr = r && !pv_r; ru = u && !pv_u; rd = d && !pv_d;
      any_rise = rl || rr || ru || rd;
      m_up = 0; m_dn = 0;
      if (!m_edit) begin
         if (p && !pv_p) begin
            m_edit = 1; m_field = LO; m_hold = 0; m_age = 0; m_idle = 0;
         end
      end else if (!p) begin
         m_edit = 0; m_field = 0; m_hold = 0;
      end else begin
         hold_at_start = m_hold;
         m_age++;
         if (m_hold) begin
            if ((u && d) || !(m_dir_up ? u : d)) m_hold = 0;
            else begin
               m_hold_age++;
               if (m_hold_age >= HOLD && ((m_hold_age - HOLD) % REP) == 0) begin
                  m_up = m_dir_up; m_dn = !m_dir_up;
               end
            end
         end else if (ru && !d) begin
            m_up = 1; m_hold = 1; m_dir_up = 1; m_hold_age = 0;
         end else if (rd && !u) begin
            m_dn = 1; m_hold = 1; m_dir_up = 0; m_hold_age = 0;
         end else if (!u && !d && (rl != rr)) begin
            if (rr) m_field = (m_field == HI) ? LO : m_field + 1;
            else    m_field = (m_field == LO) ? HI : m_field - 1;
         end
`ifdef EDIT_TIMEOUT_EN
         if (!hold_at_start && !any_rise && m_idle >= TMO - 1) begin
            m_edit = 0; m_field = 0; m_hold = 0;
         end else if (any_rise || m_up || m_dn) m_idle = 0;
         else m_idle++;
`else
         if (any_rise && hold_at_start) m_idle = 0;
`endif
      end
      pv_p = p; pv_l = l; pv_r = r; pv_u = u; pv_d = d;
   endtask

   function automatic logic [7:0] dut_outs();
      return {bus.en_count, bus.enUP, bus.enDOWN, bus.editing, bus.blink};
   endfunction

   function automatic logic [7:0] model_outs();
      logic [3:0] f;
      logic       b;
      f = 4'(m_field);
      b = m_edit ? (((m_age / BLINK) % 2) == 1) : 1'b0;
      return {f, m_up, m_dn, m_edit, b};
   endfunction

   // One clock: sample after the edge, advance the model, compare.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (!reset) model_reset();
      else        model_step();
      check("model", 32'(dut_outs()), 32'(model_outs()));
   endtask

   task automatic set_in(input bit p, input bit l, input bit r, input bit u, input bit d);
      bus.prog_mode = p; bus.btn_left = l; bus.btn_right = r; bus.btn_up = u; bus.btn_down = d;
   endtask

   typedef struct {
      bit         l;
      bit         r;
      logic [3:0] exp;
   } nav_t;

   nav_t nav[13];
   int   pulses;
   logic [6:0] blink_pat;

   initial begin
      // navigation table: 10 right presses, left wrap, left, left+right together
      for (int i = 0; i < 10; i++) nav[i] = '{l: 1'b0, r: 1'b1, exp: 4'((i + 1) % 10 + 1)};
      nav[10] = '{l: 1'b1, r: 1'b0, exp: 4'd10};
      nav[11] = '{l: 1'b1, r: 1'b0, exp: 4'd9};
      nav[12] = '{l: 1'b1, r: 1'b1, exp: 4'd9};
      blink_pat = 7'b0111000;

      // reset state
      model_reset();
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0);
      cyc(); cyc();
      check("reset_outs", 32'(dut_outs()), 32'd0);
      reset = 1'b1;

      // 1: enter edit mode
      bus.prog_mode = 1'b1;
      cyc();
      check("enter_editing", 32'(bus.editing), 32'd1);
      check("enter_field", 32'(bus.en_count), 32'd1);

      // 1+2: navigation vectors
      for (int i = 0; i < 13; i++) begin
         bus.btn_left = nav[i].l; bus.btn_right = nav[i].r;
         cyc();
         check($sformatf("nav%0d", i), 32'(bus.en_count), 32'(nav[i].exp));
         bus.btn_left = 1'b0; bus.btn_right = 1'b0;
         cyc();
      end

      // 3: up held 20 clocks -> pulses at 0, 8, 12, 16 after the press edge
      pulses = 0;
      bus.btn_up = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         check($sformatf("hold_up%0d", i), 32'(bus.enUP),
               32'((i == 0) || (i == 8) || (i == 12) || (i == 16)));
         check("hold_no_down", 32'(bus.enDOWN), 32'd0);
         check("hold_field", 32'(bus.en_count), 32'd9);
         if (bus.enUP) pulses++;
      end
      check("hold_pulse_count", 32'(pulses), 32'd4);
      bus.btn_up = 1'b0;
      cyc();

      // 4: up+down together -> no pulses
      bus.btn_up = 1'b1; bus.btn_down = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         check("both_no_pulse", 32'({bus.enUP, bus.enDOWN}), 32'd0);
      end
      bus.btn_up = 1'b0; bus.btn_down = 1'b0;
      cyc();
      // down held into repeat, then prog_mode drops
      pulses = 0;
      bus.btn_down = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (bus.enDOWN) pulses++;
      end
      check("down_pulse_count", 32'(pulses), 32'd2);
      bus.prog_mode = 1'b0;
      cyc();
      check("exit_editing", 32'(bus.editing), 32'd0);
      check("exit_field", 32'(bus.en_count), 32'd0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (bus.enDOWN || bus.enUP) pulses++;
      end
      check("exit_no_pulses", 32'(pulses), 32'd0);
      bus.prog_mode = 1'b1;
      cyc();
      check("reenter_field", 32'(bus.en_count), 32'd1);
      bus.btn_down = 1'b0;
      cyc();

      // 5: reset during REPEAT with up held through it
      bus.btn_up = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      reset = 1'b0;
      #1;
      check("async_reset_outs", 32'(dut_outs()), 32'd0);
      cyc(); cyc();
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (bus.enUP) pulses++;
      end
      check("held_through_reset", 32'(pulses), 32'd0);
      check("post_reset_editing", 32'(bus.editing), 32'd1);
      bus.btn_up = 1'b0;
      cyc();
      bus.btn_up = 1'b1;
      cyc();
      check("repress_pulse", 32'(bus.enUP), 32'd1);
      bus.btn_up = 1'b0;
      cyc();

      // 6: idle in edit mode, blink pattern and timeout behaviour
      bus.prog_mode = 1'b0;
      cyc();
      bus.prog_mode = 1'b1;
      cyc();
      check("blink_entry", 32'(bus.blink), 32'd0);
      for (int i = 1; i <= 100; i++) begin
         cyc();
         if (i <= 6) check($sformatf("blink%0d", i), 32'(bus.blink), 32'(blink_pat[i]));
`ifdef EDIT_TIMEOUT_EN
         check($sformatf("timeout_editing%0d", i), 32'(bus.editing), 32'(i < 20));
`else
         check($sformatf("no_timeout_editing%0d", i), 32'(bus.editing), 32'd1);
`endif
      end

      // randomized stimulus against the reference model
      for (int n = 0; n < 4000; n++) begin
         if (!bus.prog_mode) bus.prog_mode = ($urandom_range(0, 3) == 0);
         else if ($urandom_range(0, 99) == 0) bus.prog_mode = 1'b0;
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 3))
               0:       bus.btn_left  = ~bus.btn_left;
               1:       bus.btn_right = ~bus.btn_right;
               2:       bus.btn_up    = ~bus.btn_up;
               default: bus.btn_down  = ~bus.btn_down;
            endcase
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
